hdr_in_buf: RTL and testbench

- Ingress header buffer sitting directly upstream of the processor/AXI wrapper.
- Accepts packet header bytes as a byte stream and assembles each packet into a fixed HDR_LEN-byte header, zero-padded or truncated.
- Queues up to DEPTH assembled headers.
- Presents the head header on the in_empty/in_rd/pkt_hdr interface the processor consumes.

---
 rtl/hdr_in_buf_pkg.sv | 26 ++
 rtl/hdr_buf_mem.sv | 70 +++++++
 rtl/hdr_in_buf.sv | 111 +++++++++++
 tb/tb_hdr_in_buf.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_in_buf_pkg.sv
// Shared definitions for the ingress header buffer: byte bus, header length,
// header container type and assembler states.
`ifndef HDR_IN_BUF_DEFS
`define HDR_IN_BUF_DEFS
`define BYTE_BUS 7:0
`define HDR_MAX_LEN 16
`endif

package hdr_in_buf_pkg;

    localparam int HDR_MAX_LEN = `HDR_MAX_LEN;

    typedef logic [`BYTE_BUS] hdr_t [0:HDR_MAX_LEN-1];

    typedef enum logic [1:0] {
        FILL,
        DISCARD,
        COMMIT
    } asm_state_e;

    // Saturating 16-bit increment, used for the truncation counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/hdr_buf_mem.sv
// DEPTH-entry header queue with wrap-around pointers and occupancy count.
// Latency: push visible one cycle later; head is show-ahead; push while full only with a same-cycle pop.
import hdr_in_buf_pkg::*;

module hdr_buf_mem #(
    parameter int DEPTH   = 4,
    parameter int HDR_LEN = `HDR_MAX_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [`BYTE_BUS]        wdata_i [0:HDR_LEN-1],
    output logic [`BYTE_BUS]        rdata_o [0:HDR_LEN-1],
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [`BYTE_BUS]   mem_q [0:DEPTH-1][0:HDR_LEN-1];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               pop_ok;
    logic               push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < HDR_LEN; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/hdr_in_buf.sv
// Assembles a byte stream into fixed-length zero-padded/truncated headers and queues them.
// Latency: last byte at t, entry written t+1, visible t+2; input stalls in COMMIT while the queue is full.
import hdr_in_buf_pkg::*;

module hdr_in_buf #(
    parameter int DEPTH   = 4,
    parameter int HDR_LEN = `HDR_MAX_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid_i,
    input  logic [`BYTE_BUS]        s_data_i,
    input  logic                    s_last_i,
    output logic                    s_ready_o,
    input  logic                    rd_i,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [`BYTE_BUS]        pkt_hdr_o [0:HDR_LEN-1],
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [15:0]             trunc_cnt_o
);

    localparam int IDX_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;

    asm_state_e         state_q;
    logic [IDX_W-1:0]   wr_idx_q;
    logic [`BYTE_BUS]   stage_q [0:HDR_LEN-1];
    logic               trunc_flag_q;
    logic [15:0]        trunc_cnt_q;
    logic [15:0]        trunc_cnt_d;
    logic               s_ready_q;
    logic               byte_acc;
    logic               last_slot;
    logic               commit_ok;

    assign byte_acc    = s_valid_i && s_ready_q;
    assign last_slot   = (wr_idx_q == IDX_W'(HDR_LEN - 1));
    // A pop in the commit cycle frees the slot the staged header is written into.
    assign commit_ok   = (state_q == COMMIT) && (!full_o || (rd_i && !empty_o));
    assign trunc_cnt_d = sat_inc16(trunc_cnt_q, trunc_flag_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            wr_idx_q     <= '0;
            for (int i = 0; i < HDR_LEN; i++) begin
                stage_q[i] <= '0;
            end
            trunc_flag_q <= 1'b0;
            trunc_cnt_q  <= '0;
            s_ready_q    <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (byte_acc) begin
                        stage_q[wr_idx_q] <= s_data_i;
                        wr_idx_q          <= wr_idx_q + 1'b1;
                        if (s_last_i) begin
                            state_q   <= COMMIT;
                            s_ready_q <= 1'b0;
                        end else if (last_slot) begin
                            state_q      <= DISCARD;
                            trunc_flag_q <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (byte_acc && s_last_i) begin
                        state_q   <= COMMIT;
                        s_ready_q <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (commit_ok) begin
                        for (int i = 0; i < HDR_LEN; i++) begin
                            stage_q[i] <= '0;
                        end
                        wr_idx_q     <= '0;
                        trunc_cnt_q  <= trunc_cnt_d;
                        trunc_flag_q <= 1'b0;
                        state_q      <= FILL;
                        s_ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= FILL;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    hdr_buf_mem #(
        .DEPTH   (DEPTH),
        .HDR_LEN (HDR_LEN)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .push_i  (commit_ok),
        .pop_i   (rd_i),
        .wdata_i (stage_q),
        .rdata_o (pkt_hdr_o),
        .empty_o (empty_o),
        .full_o  (full_o),
        .count_o (count_o)
    );

    assign s_ready_o   = s_ready_q;
    assign trunc_cnt_o = trunc_cnt_q;

endmodule

// File: tb/tb_hdr_in_buf.sv
// Self-checking bench for hdr_in_buf (DEPTH=2, HDR_LEN=16) against a queue-of-headers reference model.
module tb_hdr_in_buf;

    localparam int DEPTH   = 2;
    localparam int HDR_LEN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid_i = 1'b0;
    logic [7:0]  s_data_i = '0;
    logic        s_last_i = 1'b0;
    logic        s_ready_o;
    logic        rd_i = 1'b0;
    logic        empty_o;
    logic        full_o;
    logic [7:0]  pkt_hdr_o [0:HDR_LEN-1];
    logic [1:0]  count_o;
    logic [15:0] trunc_cnt_o;

    int vec  = 0;
    int errs = 0;
    logic [127:0] model_q [$];
    int trunc_exp = 0;
    logic [7:0] tx [0:31];

    always #5 clk = ~clk;

    hdr_in_buf #(.DEPTH(DEPTH), .HDR_LEN(HDR_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .rd_i        (rd_i),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .pkt_hdr_o   (pkt_hdr_o),
        .count_o     (count_o),
        .trunc_cnt_o (trunc_cnt_o)
    );

    function automatic logic [127:0] flat_hdr();
        logic [127:0] f = '0;
        for (int i = 0; i < HDR_LEN; i++) f[127-8*i -: 8] = pkt_hdr_o[i];
        return f;
    endfunction

    // Reference: first min(len,16) bytes in order, rest zero.
    function automatic logic [127:0] expect_hdr(input int len);
        logic [127:0] e = '0;
        for (int i = 0; i < len && i < HDR_LEN; i++) e[127-8*i -: 8] = tx[i];
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic push_byte(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        while (!s_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit check_ready);
        int w;
        model_q.push_back(expect_hdr(len));
        if (len > HDR_LEN) trunc_exp++;
        for (int i = 0; i < len; i++) begin
            push_byte(tx[i], (i == len - 1), w);
            if (check_ready) begin
                vec++;
                if (w != 0) begin
                    errs++;
                    $display("FAIL ready_in_pkt byte %0d: stalled %0d cycles, want 0", i, w);
                end
            end else if (w >= 200) begin
                vec++;
                errs++;
                $display("FAIL send_timeout byte %0d: s_ready_o stuck low", i);
            end
        end
    endtask

    task automatic pop_check(input string nm);
        int w = 0;
        logic [127:0] got;
        while (empty_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        vec++;
        if (w >= 200 || model_q.size() == 0) begin
            errs++;
            $display("FAIL %s_pop_wait: empty_o=%0b model_size=%0d", nm, empty_o, model_q.size());
            return;
        end
        got = flat_hdr();
        if (got !== model_q[0]) begin
            errs++;
            $display("FAIL %s_hdr: got %h want %h", nm, got, model_q[0]);
        end
        rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        void'(model_q.pop_front());
    endtask

    task automatic check_idle_outputs(input string nm);
        vec++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || s_ready_o !== 1'b1 || count_o !== 2'd0
            || trunc_cnt_o !== 16'd0 || flat_hdr() !== 128'd0) begin
            errs++;
            $display("FAIL %s: empty=%0b full=%0b rdy=%0b cnt=%0d trunc=%0d hdr=%h, want 1 0 1 0 0 0",
                     nm, empty_o, full_o, s_ready_o, count_o, trunc_cnt_o, flat_hdr());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
    endtask

    task automatic test_short();
        for (int i = 0; i < 5; i++) tx[i] = 8'(i + 1);
        send_pkt(5, 1'b0);
        vec++;
        if (empty_o !== 1'b1) begin
            errs++;
            $display("FAIL short_latency_t1: empty_o=%0b want 1", empty_o);
        end
        @(negedge clk);
        vec++;
        if (empty_o !== 1'b0 || count_o !== 2'd1) begin
            errs++;
            $display("FAIL short_latency_t2: empty_o=%0b count=%0d want 0 1", empty_o, count_o);
        end
        pop_check("short");
        vec++;
        if (empty_o !== 1'b1 || count_o !== 2'd0) begin
            errs++;
            $display("FAIL short_after_pop: empty_o=%0b count=%0d want 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_trunc();
        for (int i = 0; i < 20; i++) tx[i] = 8'(i);
        send_pkt(20, 1'b1);
        @(negedge clk);
        vec++;
        if (trunc_cnt_o !== 16'(trunc_exp) || count_o !== 2'd1) begin
            errs++;
            $display("FAIL trunc_cnt: got %0d cnt=%0d want %0d 1", trunc_cnt_o, count_o, trunc_exp);
        end
        pop_check("trunc");
    endtask

    task automatic test_full();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
            send_pkt(4, 1'b0);
        end
        @(negedge clk);
        vec++;
        if (full_o !== 1'b1 || count_o !== 2'd2) begin
            errs++;
            $display("FAIL full_after_two: full=%0b count=%0d want 1 2", full_o, count_o);
        end
        for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
        send_pkt(4, 1'b0);
        @(negedge clk);
        vec++;
        if (s_ready_o !== 1'b0 || count_o !== 2'd2) begin
            errs++;
            $display("FAIL commit_stall: ready=%0b count=%0d want 0 2", s_ready_o, count_o);
        end
        pop_check("full_a");
        vec++;
        if (count_o !== 2'd2 || full_o !== 1'b1 || s_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL pop_commit_same_cycle: count=%0d full=%0b ready=%0b want 2 1 1",
                     count_o, full_o, s_ready_o);
        end
        pop_check("full_b");
        pop_check("full_c");
        vec++;
        if (empty_o !== 1'b1 || count_o !== 2'd0) begin
            errs++;
            $display("FAIL full_drain: empty=%0b count=%0d want 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_rd_empty();
        rd_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec++;
            if (count_o !== 2'd0 || empty_o !== 1'b1) begin
                errs++;
                $display("FAIL rd_on_empty: count=%0d empty=%0b want 0 1", count_o, empty_o);
            end
        end
        rd_i = 1'b0;
        for (int i = 0; i < 7; i++) tx[i] = 8'($urandom);
        send_pkt(7, 1'b0);
        pop_check("after_rd_empty");
    endtask

    task automatic test_mid_reset();
        int w;
        for (int i = 0; i < 6; i++) tx[i] = 8'($urandom);
        send_pkt(6, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_byte(8'hA0 + 8'(i), 1'b0, w);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        model_q.delete();
        trunc_exp = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tx[0] = 8'h5A;
        tx[1] = 8'hC3;
        send_pkt(2, 1'b0);
        pop_check("post_reset");
    endtask

    task automatic test_back_to_back();
        int popped = 0;
        fork
            begin
                for (int p = 0; p < 10; p++) begin
                    int len = $urandom_range(1, 20);
                    for (int i = 0; i < len; i++) tx[i] = 8'($urandom);
                    send_pkt(len, 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                int cyc = 0;
                while (popped < 10 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    rd_i = 1'b0;
                    if (!empty_o && $urandom_range(0, 3) != 0) begin
                        vec++;
                        if (model_q.size() == 0 || flat_hdr() !== model_q[0]) begin
                            errs++;
                            $display("FAIL b2b_hdr %0d: got %h want %h", popped, flat_hdr(),
                                     (model_q.size() != 0) ? model_q[0] : 128'd0);
                        end
                        if (model_q.size() != 0) void'(model_q.pop_front());
                        popped++;
                        rd_i = 1'b1;
                    end
                end
                @(negedge clk);
                rd_i = 1'b0;
            end
        join
        vec++;
        if (popped != 10 || empty_o !== 1'b1 || count_o !== 2'd0) begin
            errs++;
            $display("FAIL b2b_drain: popped=%0d empty=%0b count=%0d want 10 1 0", popped, empty_o, count_o);
        end
        vec++;
        if (trunc_cnt_o !== 16'(trunc_exp)) begin
            errs++;
            $display("FAIL b2b_trunc_cnt: got %0d want %0d", trunc_cnt_o, trunc_exp);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_short();
        test_trunc();
        test_full();
        test_rd_empty();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
